// File: rtl/ushift_reg.sv
// rtl/ushift_reg.sv - universal shift register with load, multi-step shift/rotate and start/busy/done handshake
module ushift_reg #(
    parameter int               WIDTH   = 8,
    parameter int               AW      = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic             dir,
    input  logic [AW-1:0]    amt,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_lsb,
    input  logic             sin_msb,
    output logic [WIDTH-1:0] q,
    output logic             sout,
    output logic             busy,
    output logic             done
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [1:0] OP_HOLD = 2'b00;
    localparam logic [1:0] OP_LOAD = 2'b01;

    state_t           state_q;
    logic [AW-1:0]    cnt_q;
    logic             rot_q;
    logic             dir_q;
    logic [WIDTH-1:0] q_q;
    logic             sout_q;
    logic             busy_q;
    logic             done_q;

    logic [WIDTH-1:0] step_q_d;
    logic             step_sout_d;

    // One step using the latched command; serial bits are taken live from the pins.
    always_comb begin
        step_q_d    = q_q;
        step_sout_d = sout_q;
        if (dir_q == 1'b0) begin
            step_q_d    = {q_q[WIDTH-2:0], (rot_q ? q_q[WIDTH-1] : sin_lsb)};
            step_sout_d = q_q[WIDTH-1];
        end else begin
            step_q_d    = {(rot_q ? q_q[0] : sin_msb), q_q[WIDTH-1:1]};
            step_sout_d = q_q[0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rot_q   <= 1'b0;
            dir_q   <= 1'b0;
            q_q     <= RST_VAL;
            sout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (op == OP_HOLD) begin
                            done_q <= 1'b1;
                        end else if (op == OP_LOAD) begin
                            q_q    <= d;
                            done_q <= 1'b1;
                        end else if (amt == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            rot_q   <= op[0];
                            dir_q   <= dir;
                            cnt_q   <= amt;
                            busy_q  <= 1'b1;
                            state_q <= RUN;
                        end
                    end
                end
                RUN: begin
                    q_q    <= step_q_d;
                    sout_q <= step_sout_d;
                    cnt_q  <= cnt_q - 1'b1;
                    if (cnt_q == {{(AW-1){1'b0}}, 1'b1}) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign q    = q_q;
    assign sout = sout_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: doc/ushift_reg.md
# ushift_reg

Parametrised universal shift register built on the team's positive-edge D flip-flop. It adds asynchronous reset, parallel load, multi-position shift and rotate in either direction, and a start/busy/done handshake. It is the register primitive for the next lab exercises: serial-parallel conversion, rotators and LFSR front ends.

## Interface
Parameters:
- `WIDTH`, 8: register width in bits (≥2).
- `AW`, 4: width of the shift-amount field. Maximum amount is 2^AW−1.
- `RST_VAL`, 0: value of `q` while in reset (WIDTH bits).

Ports:
- `clk` input 1: clock. All state changes on the rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `start` input 1: command strobe. Sampled only when `busy`=0.
- `op` input 2: command. 00 hold, 01 load, 10 shift, 11 rotate.
- `dir` input 1: 0 = left (toward MSB), 1 = right (toward LSB).
- `amt` input AW: number of one-bit steps for shift/rotate.
- `d` input WIDTH: parallel load data.
- `sin_lsb` input 1: serial bit entering `q[0]` on a left shift.
- `sin_msb` input 1: serial bit entering `q[WIDTH-1]` on a right shift.
- `q` output WIDTH: register contents.
- `sout` output 1: bit that left (or wrapped) on the most recent step.
- `busy` output 1: multi-step operation in progress.
- `done` output 1: one-cycle completion pulse.

## Operation
- **Reset** (`rst_n`=0, immediate, no clock needed):
  - `q`=RST_VAL, `sout`=0, `busy`=0, `done`=0.
  - Internal step counter=0, FSM=IDLE.
  - Any operation in flight is aborted.
- **FSM states:** IDLE and RUN.
- **IDLE:** `q` holds. `done` is high only on the cycle after a completion.
- **start in IDLE, op=00:** no change to `q`. `done`=1 for one cycle.
- **start in IDLE, op=01:**
  - `q`←`d` at the sampling edge; `done`=1 for one cycle.
  - `sout` unchanged.
- **start in IDLE, op=10/11, amt=0:** `q` unchanged. `done`=1 for one cycle. `busy` stays 0.
- **start in IDLE, op=10/11, amt>0:**
  - Latch op, dir and amt; counter←amt.
  - Go to RUN; `busy`=1.
- **RUN:** one step per edge, then counter−1. When the counter reaches 0: `busy`←0, `done`←1, FSM→IDLE.
- **Step definitions:**
  - Left shift: `q`←{`q[WIDTH-2:0]`, `sin_lsb`}, `sout`←old `q[WIDTH-1]`.
  - Right shift: `q`←{`sin_msb`, `q[WIDTH-1:1]`}, `sout`←old `q[0]`.
  - Left rotate: `q`←{`q[WIDTH-2:0]`, `q[WIDTH-1]`}, `sout`←old `q[WIDTH-1]`.
  - Right rotate: `q`←{`q[0]`, `q[WIDTH-1:1]`}, `sout`←old `q[0]`.
- **Serial inputs:** sampled live on every step edge, not latched at start, so a bit stream can be fed through `sin_*`.
- **Amounts:** amt ≥ WIDTH is legal.
  - Shift: the register is fully replaced by serial input.
  - Rotate: the result equals rotation by amt mod WIDTH.
- **Command inputs while busy:** `start`, `op`, `dir`, `amt` and `d` are ignored.
- **done:** never asserted together with `busy`=1.

## Timing
- **Load/hold/amt=0:** start sampled at edge k → result and `done`=1 after edge k; `done`=0 after edge k+1.
- **Shift/rotate amt=N>0:** start sampled at edge k.
  - `busy`=1 after edge k.
  - Steps occur at edges k+1 … k+N.
  - After edge k+N: `busy`=0, `done`=1.
  - `done`=0 after edge k+N+1.
- **Back-to-back commands:** the next start can be sampled at edge k+N+1, when `busy`=0 and `done`=1. Sustained throughput is N+1 cycles per operation.
- **Outputs:** all outputs are registered. No combinational path from inputs to outputs.

## Test plan
- **Reset:** RST_VAL=8'hA5, drive `rst_n`=0 between clock edges → `q`=A5, `busy`=`done`=`sout`=0 immediately. Release → values hold.
- **Load:** `d`=8'h3C, op=01, start for one cycle → `q`=3C after 1 edge, `done` pulses exactly one cycle, `busy` never rises.
- **Left shift:** from `q`=3C, op=10, dir=0, amt=3, `sin_lsb`=1 → `q`=79, F3, E7 on successive edges; `sout`=0, 0, 1; `busy` high 3 cycles; `done` pulse after the 3rd step.
- **Right rotate wrap:** from `q`=81, op=11, dir=1, amt=8 → first step `q`=C0, `sout`=1. After 8 steps `q`=81, with `busy` high for 8 cycles.
- **Ignored start / zero amount:** pulse start with op=01, `d`=FF during a RUN → `q` is not loaded. Then op=10, amt=0 → `q` unchanged, `done` after 1 edge, `busy`=0.
- **Reset mid-op:** shift amt=10; assert `rst_n`=0 after 4 steps → `q`=RST_VAL, `busy`=0 at once, no `done` pulse. A new load after release works.
